// File: rtl/cpu_ctrl_pkg.sv
// Shared state encodings, output constants and the Moore output decode
// for the CPU control FSM.
package cpu_ctrl_pkg;

    typedef enum logic [5:0] {
        S_RST, S_IF1, S_IF2, S_UPDATE, S_DECODE,
        S_MOVIM_W, S_MOV_B, S_MOV_C, S_MOV_W,
        S_ALU_A, S_ALU_B, S_ALU_C, S_ALU_W,
        S_CMP_A, S_CMP_B, S_CMP_S,
        S_MVN_B, S_MVN_C, S_MVN_W,
        S_LDR_A, S_LDR_C, S_LDR_ADDR, S_MEM_RD, S_LDR_W,
        S_STR_A, S_STR_C, S_STR_ADDR, S_STR_B, S_STR_C2, S_MEM_WR,
        S_BR1, S_BL_W, S_BL_PC,
        S_BX_B, S_BX_C, S_BX_PC,
        S_BLX_B, S_BLX_C, S_BLX_W, S_BLX_PC,
        S_HALT, S_ILLEGAL
    } state_e;

    localparam logic [3:0] VSEL_C      = 4'b0001;
    localparam logic [3:0] VSEL_PC     = 4'b0010;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
    localparam logic [3:0] VSEL_MDATA  = 4'b1000;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef struct packed {
        logic [3:0] vsel;
        logic [2:0] nsel;
        logic [1:0] pc_sel;
        logic [1:0] mem_cmd;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST:      begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:      begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
            S_IF2:      begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
            S_UPDATE:   begin c.load_pc = 1'b1; c.pc_sel = PC_INC; end
            S_MOVIM_W:  begin c.write = 1'b1; c.vsel = VSEL_SXIMM8; c.nsel = NSEL_RN; end
            S_MOV_B, S_ALU_B, S_CMP_B, S_MVN_B:
                        begin c.loadb = 1'b1; c.nsel = NSEL_RM; end
            S_ALU_A, S_CMP_A, S_LDR_A, S_STR_A:
                        begin c.loada = 1'b1; c.nsel = NSEL_RN; end
            S_MOV_C, S_STR_C2, S_BX_C, S_BLX_C:
                        begin c.loadc = 1'b1; c.asel = 1'b1; end
            S_ALU_C, S_MVN_C:   c.loadc = 1'b1;
            S_LDR_C, S_STR_C:   begin c.loadc = 1'b1; c.bsel = 1'b1; end
            S_LDR_ADDR, S_STR_ADDR: c.load_addr = 1'b1;
            S_MOV_W, S_ALU_W, S_MVN_W:
                        begin c.write = 1'b1; c.vsel = VSEL_C; c.nsel = NSEL_RD; end
            S_CMP_S:    c.loads = 1'b1;
            S_MEM_RD:   c.mem_cmd = MEM_READ;
            S_LDR_W:    begin c.write = 1'b1; c.vsel = VSEL_MDATA; c.nsel = NSEL_RD; c.mem_cmd = MEM_READ; end
            S_STR_B, S_BX_B, S_BLX_B:
                        begin c.loadb = 1'b1; c.nsel = NSEL_RD; end
            S_MEM_WR:   c.mem_cmd = MEM_WRITE;
            S_BL_W, S_BLX_W:
                        begin c.write = 1'b1; c.vsel = VSEL_PC; c.nsel = NSEL_RN; end
            S_BR1, S_BL_PC:     begin c.load_pc = 1'b1; c.pc_sel = PC_REL; end
            S_BX_PC, S_BLX_PC:  begin c.load_pc = 1'b1; c.pc_sel = PC_REG; end
            S_HALT:     c.halted = 1'b1;
            S_ILLEGAL:  begin c.halted = 1'b1; c.illegal = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_br_cond_eval.sv
// Branch condition evaluation from the N/V/Z status flags.
module br_cond_eval (
    input  logic [2:0] cond_i,
    input  logic       n_i,
    input  logic       v_i,
    input  logic       z_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            3'b000:  taken_o = 1'b1;
            3'b001:  taken_o = z_i;
            3'b010:  taken_o = ~z_i;
            3'b011:  taken_o = n_i ^ v_i;
            3'b100:  taken_o = (n_i ^ v_i) | z_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU controller: fetch, decode and per-instruction sequences
// with Moore outputs registered alongside the state.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_BRANCH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    input  logic       mem_ready,
    output logic [3:0] vsel,
    output logic [2:0] nsel,
    output logic [1:0] pc_sel,
    output logic [1:0] mem_cmd,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic       halted,
    output logic       illegal
);

    localparam bit BRANCH_EN = (ENABLE_BRANCH != 0);

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   taken;
    logic   mem_done;

    br_cond_eval u_cond (
        .cond_i  (cond),
        .n_i     (N),
        .v_i     (V),
        .z_i     (Z),
        .taken_o (taken)
    );

    assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_IF1;
            S_IF1:      if (mem_done) state_d = S_IF2;
            S_IF2:      state_d = S_UPDATE;
            S_UPDATE:   state_d = S_DECODE;
            S_DECODE: begin
                case ({opcode, op})
                    5'b110_10: state_d = S_MOVIM_W;
                    5'b110_00: state_d = S_MOV_B;
                    5'b101_00,
                    5'b101_10: state_d = S_ALU_A;
                    5'b101_01: state_d = S_CMP_A;
                    5'b101_11: state_d = S_MVN_B;
                    5'b011_00: state_d = S_LDR_A;
                    5'b100_00: state_d = S_STR_A;
                    5'b001_00: state_d = !BRANCH_EN ? S_ILLEGAL : (taken ? S_BR1 : S_IF1);
                    5'b010_11: state_d = BRANCH_EN ? S_BL_W  : S_ILLEGAL;
                    5'b010_00: state_d = BRANCH_EN ? S_BX_B  : S_ILLEGAL;
                    5'b010_10: state_d = BRANCH_EN ? S_BLX_B : S_ILLEGAL;
                    default:   state_d = (opcode == 3'b111) ? S_HALT : S_ILLEGAL;
                endcase
            end
            S_MOV_B:    state_d = S_MOV_C;
            S_MOV_C:    state_d = S_MOV_W;
            S_ALU_A:    state_d = S_ALU_B;
            S_ALU_B:    state_d = S_ALU_C;
            S_ALU_C:    state_d = S_ALU_W;
            S_CMP_A:    state_d = S_CMP_B;
            S_CMP_B:    state_d = S_CMP_S;
            S_MVN_B:    state_d = S_MVN_C;
            S_MVN_C:    state_d = S_MVN_W;
            S_LDR_A:    state_d = S_LDR_C;
            S_LDR_C:    state_d = S_LDR_ADDR;
            S_LDR_ADDR: state_d = S_MEM_RD;
            S_MEM_RD:   if (mem_done) state_d = S_LDR_W;
            S_STR_A:    state_d = S_STR_C;
            S_STR_C:    state_d = S_STR_ADDR;
            S_STR_ADDR: state_d = S_STR_B;
            S_STR_B:    state_d = S_STR_C2;
            S_STR_C2:   state_d = S_MEM_WR;
            S_MEM_WR:   if (mem_done) state_d = S_IF1;
            S_BL_W:     state_d = S_BL_PC;
            S_BX_B:     state_d = S_BX_C;
            S_BX_C:     state_d = S_BX_PC;
            S_BLX_B:    state_d = S_BLX_C;
            S_BLX_C:    state_d = S_BLX_W;
            S_BLX_W:    state_d = S_BLX_PC;
            S_MOVIM_W, S_MOV_W, S_ALU_W, S_CMP_S, S_MVN_W, S_LDR_W,
            S_BR1, S_BL_PC, S_BX_PC, S_BLX_PC:
                        state_d = S_IF1;
            S_HALT:     state_d = S_HALT;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_RST;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            ctrl_q  <= ctrl_decode(S_RST);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_decode(state_d);
        end
    end

    assign vsel      = ctrl_q.vsel;
    assign nsel      = ctrl_q.nsel;
    assign pc_sel    = ctrl_q.pc_sel;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign halted    = ctrl_q.halted;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed table, corner sequences and
// random instructions against a per-instruction micro-op sequence model.
module tb_cpu_ctrl_fsm;

    logic       clk, reset;
    logic [2:0] opcode, cond;
    logic [1:0] op;
    logic       N, V, Z, mem_ready;
    logic [3:0] vsel;
    logic [2:0] nsel;
    logic [1:0] pc_sel, mem_cmd;
    logic write, loada, loadb, loadc, loads, asel, bsel, load_ir, load_pc;
    logic reset_pc, addr_sel, load_addr, halted, illegal;

    cpu_ctrl_fsm #(.MEM_HANDSHAKE(1), .ENABLE_BRANCH(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .N(N), .V(V), .Z(Z), .mem_ready(mem_ready),
        .vsel(vsel), .nsel(nsel), .pc_sel(pc_sel), .mem_cmd(mem_cmd),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .load_ir(load_ir), .load_pc(load_pc),
        .reset_pc(reset_pc), .addr_sel(addr_sel), .load_addr(load_addr),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All outputs flattened into one vector; bit positions below.
    logic [24:0] act;
    assign act = {vsel, nsel, pc_sel, mem_cmd, write, loada, loadb, loadc, loads,
                  asel, bsel, load_ir, load_pc, reset_pc, addr_sel, load_addr, halted, illegal};

    localparam logic [24:0] ILL   = 25'd1;
    localparam logic [24:0] HLT   = 25'd1 << 1;
    localparam logic [24:0] LADDR = 25'd1 << 2;
    localparam logic [24:0] ASELV = 25'd1 << 3;
    localparam logic [24:0] RPC   = 25'd1 << 4;
    localparam logic [24:0] LPC   = 25'd1 << 5;
    localparam logic [24:0] LIR   = 25'd1 << 6;
    localparam logic [24:0] BSL   = 25'd1 << 7;
    localparam logic [24:0] ASL   = 25'd1 << 8;
    localparam logic [24:0] LS    = 25'd1 << 9;
    localparam logic [24:0] LC    = 25'd1 << 10;
    localparam logic [24:0] LB    = 25'd1 << 11;
    localparam logic [24:0] LA    = 25'd1 << 12;
    localparam logic [24:0] W     = 25'd1 << 13;
    localparam logic [24:0] MC_RD = 25'd1 << 14;
    localparam logic [24:0] MC_WR = 25'd2 << 14;
    localparam logic [24:0] PC_SX = 25'd1 << 16;
    localparam logic [24:0] PC_C  = 25'd2 << 16;
    localparam logic [24:0] NS_RM = 25'd1 << 18;
    localparam logic [24:0] NS_RD = 25'd2 << 18;
    localparam logic [24:0] NS_RN = 25'd4 << 18;
    localparam logic [24:0] VS_C  = 25'd1 << 21;
    localparam logic [24:0] VS_PC = 25'd2 << 21;
    localparam logic [24:0] VS_SX = 25'd4 << 21;
    localparam logic [24:0] VS_MD = 25'd8 << 21;
    localparam logic [24:0] RSTV  = RPC | LPC;
    localparam logic [24:0] IF1V  = ASELV | MC_RD;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [24:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %07h expected %07h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: list of post-DECODE output vectors for one instruction.
    typedef struct {
        logic [7:0][24:0] vec;
        logic [7:0]       wt;
        int               len;
        bit               term;
    } seq_t;

    function automatic seq_t app(seq_t s, logic [24:0] v, bit w);
        s.vec[s.len] = v;
        s.wt[s.len]  = w;
        s.len++;
        return s;
    endfunction

    function automatic seq_t ref_seq(logic [2:0] opc, logic [1:0] o, logic [2:0] c,
                                     logic n, logic v, logic z);
        seq_t s;
        bit   tk;
        s.vec = '0; s.wt = '0; s.len = 0; s.term = 0;
        tk = (c == 3'd0) || (c == 3'd1 && z) || (c == 3'd2 && !z) ||
             (c == 3'd3 && (n != v)) || (c == 3'd4 && ((n != v) || z));
        case ({opc, o})
            5'b110_10: s = app(s, W | VS_SX | NS_RN, 0);
            5'b110_00: begin s = app(s, LB | NS_RM, 0); s = app(s, LC | ASL, 0); s = app(s, W | VS_C | NS_RD, 0); end
            5'b101_00, 5'b101_10: begin
                s = app(s, LA | NS_RN, 0); s = app(s, LB | NS_RM, 0);
                s = app(s, LC, 0); s = app(s, W | VS_C | NS_RD, 0);
            end
            5'b101_01: begin s = app(s, LA | NS_RN, 0); s = app(s, LB | NS_RM, 0); s = app(s, LS, 0); end
            5'b101_11: begin s = app(s, LB | NS_RM, 0); s = app(s, LC, 0); s = app(s, W | VS_C | NS_RD, 0); end
            5'b011_00: begin
                s = app(s, LA | NS_RN, 0); s = app(s, LC | BSL, 0); s = app(s, LADDR, 0);
                s = app(s, MC_RD, 1); s = app(s, W | VS_MD | NS_RD | MC_RD, 0);
            end
            5'b100_00: begin
                s = app(s, LA | NS_RN, 0); s = app(s, LC | BSL, 0); s = app(s, LADDR, 0);
                s = app(s, LB | NS_RD, 0); s = app(s, LC | ASL, 0); s = app(s, MC_WR, 1);
            end
            5'b001_00: if (tk) s = app(s, LPC | PC_SX, 0);
            5'b010_11: begin s = app(s, W | VS_PC | NS_RN, 0); s = app(s, LPC | PC_SX, 0); end
            5'b010_00: begin s = app(s, LB | NS_RD, 0); s = app(s, LC | ASL, 0); s = app(s, LPC | PC_C, 0); end
            5'b010_10: begin
                s = app(s, LB | NS_RD, 0); s = app(s, LC | ASL, 0);
                s = app(s, W | VS_PC | NS_RN, 0); s = app(s, LPC | PC_C, 0);
            end
            default: begin
                s = app(s, (opc == 3'b111) ? HLT : (HLT | ILL), 0);
                s.term = 1;
            end
        endcase
        return s;
    endfunction

    task automatic do_reset(input int cyc);
        reset = 1'b0;
        #1 check("rst_async", RSTV);
        repeat (cyc) begin
            @(negedge clk);
            check("rst_hold", RSTV);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Entry and exit: at a negedge with the DUT in IF1.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                             input logic [2:0] nvz, input int if_wait, input int mem_wait,
                             input bit abort, output logic [24:0] last);
        seq_t s;
        s = ref_seq(opc, o, c, nvz[2], nvz[1], nvz[0]);
        check("if1", IF1V);
        for (int k = 0; k < if_wait; k++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            check("if1_hold", IF1V);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("if2", IF1V | LIR);
        mem_ready = 1'($urandom);
        opcode = opc; op = o; cond = c; {N, V, Z} = nvz;
        @(negedge clk);
        check("update", LPC);
        @(negedge clk);
        check("decode", 25'd0);
        last = act;
        for (int i = 0; i < s.len; i++) begin
            @(negedge clk);
            check("step", s.vec[i]);
            last = act;
            if (s.wt[i]) begin
                if (abort) begin
                    mem_ready = 1'b0;
                    #2 do_reset(2);
                    return;
                end
                for (int k = 0; k < mem_wait; k++) begin
                    mem_ready = 1'b0;
                    @(negedge clk);
                    check("mem_hold", s.vec[i]);
                end
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom);
            end
        end
        if (s.term) begin
            repeat (10) begin
                @(negedge clk);
                check("halt_hold", s.vec[s.len-1]);
            end
            do_reset(2);
        end else begin
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  opc;
        logic [1:0]  o;
        logic [2:0]  c;
        logic [2:0]  nvz;
        int          if_wait;
        int          mem_wait;
        logic [24:0] exp_last;
        string       name;
    } vec_t;

    vec_t        tbl[16];
    logic [4:0]  legal[12];
    logic [24:0] last;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b110, 2'b10, 3'd0, 3'b000, 3, 0, W | VS_SX | NS_RN, "movim"};
        tbl[1]  = '{3'b110, 2'b00, 3'd0, 3'b000, 0, 0, W | VS_C | NS_RD, "mov"};
        tbl[2]  = '{3'b101, 2'b00, 3'd0, 3'b000, 1, 0, W | VS_C | NS_RD, "add"};
        tbl[3]  = '{3'b101, 2'b10, 3'd0, 3'b000, 0, 0, W | VS_C | NS_RD, "and"};
        tbl[4]  = '{3'b101, 2'b01, 3'd0, 3'b000, 0, 0, LS, "cmp"};
        tbl[5]  = '{3'b101, 2'b11, 3'd0, 3'b000, 2, 0, W | VS_C | NS_RD, "mvn"};
        tbl[6]  = '{3'b011, 2'b00, 3'd0, 3'b000, 0, 2, W | VS_MD | NS_RD | MC_RD, "ldr"};
        tbl[7]  = '{3'b100, 2'b00, 3'd0, 3'b000, 0, 1, MC_WR, "str"};
        tbl[8]  = '{3'b001, 2'b00, 3'd1, 3'b001, 0, 0, LPC | PC_SX, "beq_taken"};
        tbl[9]  = '{3'b001, 2'b00, 3'd1, 3'b000, 0, 0, 25'd0, "beq_not"};
        tbl[10] = '{3'b001, 2'b00, 3'd3, 3'b100, 0, 0, LPC | PC_SX, "blt_taken"};
        tbl[11] = '{3'b001, 2'b00, 3'd4, 3'b000, 0, 0, 25'd0, "ble_not"};
        tbl[12] = '{3'b001, 2'b00, 3'd5, 3'b111, 0, 0, 25'd0, "bcond5_never"};
        tbl[13] = '{3'b010, 2'b11, 3'd0, 3'b000, 0, 0, LPC | PC_SX, "bl"};
        tbl[14] = '{3'b010, 2'b00, 3'd0, 3'b000, 0, 0, LPC | PC_C, "bx"};
        tbl[15] = '{3'b010, 2'b10, 3'd0, 3'b000, 0, 0, LPC | PC_C, "blx"};
        legal = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_10, 5'b101_01, 5'b101_11,
                  5'b011_00, 5'b100_00, 5'b001_00, 5'b010_11, 5'b010_00, 5'b010_10};

        reset = 1'b1; mem_ready = 1'b0;
        opcode = '0; op = '0; cond = '0; N = 0; V = 0; Z = 0;
        #1 do_reset(3);

        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i].opc, tbl[i].o, tbl[i].c, tbl[i].nvz,
                      tbl[i].if_wait, tbl[i].mem_wait, 1'b0, last);
            n_tests++;
            if (last !== tbl[i].exp_last) begin
                n_fail++;
                $display("FAIL tbl_%s: last got %07h expected %07h", tbl[i].name, last, tbl[i].exp_last);
            end
        end

        run_instr(3'b111, 2'b01, 3'd0, 3'b000, 0, 0, 1'b0, last);
        run_instr(3'b000, 2'b00, 3'd0, 3'b000, 1, 0, 1'b0, last);
        run_instr(3'b100, 2'b00, 3'd0, 3'b000, 0, 3, 1'b1, last);
        run_instr(3'b011, 2'b00, 3'd0, 3'b000, 0, 3, 1'b1, last);

        for (int t = 0; t < 60; t++) begin
            logic [4:0] enc;
            enc = ($urandom_range(0, 99) < 85) ? legal[$urandom_range(0, 11)] : 5'($urandom);
            run_instr(enc[4:2], enc[1:0], 3'($urandom), 3'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0), last);
        end
        check("final_if1", IF1V);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and one reset: `clk` in, 1, rising-edge clock; `reset` in, 1, asynchronous active-low reset.
REQ-002 Parameter `MEM_HANDSHAKE`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` is ignored and every memory state lasts exactly one cycle.
REQ-003 Parameter `ENABLE_BRANCH`, default 1: 0 = opcodes 001 and 010 are treated as illegal.
REQ-004 Inputs SHALL be: `opcode` 3, instruction opcode; `op` 2, ALU/branch sub-op; `cond` 3, branch condition (IR[10:8]); `N`,`V`,`Z` 1 each, status flags; `mem_ready` 1, memory done.
REQ-005 Outputs SHALL be: `vsel` 4, one-hot write-back select (C=0001, PC=0010, sximm8=0100, mdata=1000); `nsel` 3, one-hot register select (Rn=100, Rd=010, Rm=001); `pc_sel` 2, next PC (00 PC+1, 01 PC+sximm8, 10 C).
REQ-006 Outputs SHALL also be: `mem_cmd` 2 (00 NONE, 01 READ, 10 WRITE); and 1 bit each: `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `load_ir`, `load_pc`, `reset_pc`, `addr_sel`, `load_addr`, `halted`, `illegal`.

Function
REQ-007 Outputs SHALL be a Moore decode of the present state; every unlisted output is 0.
REQ-008 Fetch sequence, one cycle per state unless stated:
- RST: reset_pc=1, load_pc=1.
- IF1: addr_sel=1, mem_cmd=READ; held until mem_ready.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1.
- UPDATE: load_pc=1, pc_sel=00.
- DECODE: all outputs 0.
REQ-009 DECODE SHALL dispatch on {opcode,op} as follows; every instruction sequence ends by going to IF1.
- 110_10 MOVim: write, vsel=sximm8, nsel=Rn.
- 110_00 MOV: loadb Rm; loadc, asel=1; write, vsel=C, nsel=Rd.
- 101_00 ADD and 101_10 AND: loada Rn; loadb Rm; loadc; write C to Rd.
- 101_01 CMP: loada Rn; loadb Rm; loads.
- 101_11 MVN: loadb Rm; loadc; write C to Rd.
REQ-010 LDR (011_00): loada Rn; loadc, bsel=1; load_addr; MEM_RD (mem_cmd=READ, addr_sel=0, held until mem_ready); write, vsel=mdata, nsel=Rd, mem_cmd=READ.
REQ-011 STR (100_00): loada Rn; loadc, bsel=1; load_addr; loadb Rd; loadc, asel=1; MEM_WR (mem_cmd=WRITE, addr_sel=0, held until mem_ready).
REQ-012 B (001_00) SHALL evaluate the condition in DECODE: cond 000 always, 001 Z, 010 ~Z, 011 N^V, 100 (N^V)|Z, other values never taken.
- Taken: BR1 with load_pc=1, pc_sel=01.
- Not taken: go directly to IF1.
REQ-013 BL (010_11): write, vsel=PC, nsel=Rn; then load_pc, pc_sel=01.
REQ-014 BX (010_00): loadb Rd; loadc, asel=1; load_pc, pc_sel=10.
REQ-015 BLX (010_10): loadb Rd; loadc, asel=1; write PC to Rn; load_pc, pc_sel=10.
REQ-016 HALT (111_xx) SHALL enter HALT: halted=1, absorbing until reset.
REQ-017 Any other {opcode,op} (including branches when ENABLE_BRANCH=0) SHALL enter HALT with illegal=1.
REQ-018 Held memory states SHALL keep all outputs constant until the cycle mem_ready=1 is sampled, then advance.
REQ-019 An unused state encoding SHALL transition to RST.

Reset
REQ-020 `reset`=0 SHALL force the RST state immediately, including mid-instruction or mid-wait; outputs then equal the RST decode.
REQ-021 The first edge after `reset` deasserts SHALL move RST to IF1.

Structure
REQ-022 State encodings and the vsel/nsel/mem_cmd/pc_sel constants SHALL live in the shared package `cpu_ctrl_pkg`.
REQ-023 Condition evaluation SHALL be one combinational sub-module, `br_cond_eval` (cond, N, V, Z -> taken).

Verification
REQ-024 Reset: hold reset=0 for 3 cycles, then release -> reset_pc=1 during reset; IF1 on the first edge after release.
REQ-025 MOVim with mem_ready held 0 for 3 cycles in IF1 -> IF1 outputs stable 4 cycles; then IF2, UPDATE, DECODE, then write=1, vsel=0100, nsel=100.
REQ-026 LDR with mem_ready asserted 2 cycles late -> MEM_RD lasts 3 cycles; the following state has write=1, vsel=1000, nsel=010.
REQ-027 BEQ with Z=1 -> BR1 has load_pc=1, pc_sel=01; with Z=0 -> DECODE goes to IF1 with no load_pc.
REQ-028 BLX -> write=1, vsel=0010, nsel=100, followed by load_pc=1, pc_sel=10.
REQ-029 opcode 000 -> halted=1, illegal=1, stays halted 10 cycles; reset=0 pulsed during MEM_WR of a STR -> RST at once.
